// File: rtl/pipeline_memory_writeback.sv
// Final CPU stage: retires ALU results to the register file and runs loads/stores
// through a req/ready handshake with data memory, stalling upstream while busy.
module pipeline_memory_writeback #(
  parameter logic [3:0] LOAD_OPC  = 4'b1000,
  parameter logic [3:0] STORE_OPC = 4'b1001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        execute_done,
  input  logic        execute_is_dependent,
  input  logic [15:0] execute_result,
  input  logic [15:0] execute_instr,
  output logic [2:0]  store_src_num,
  input  logic [15:0] store_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        wb_en,
  output logic [2:0]  wb_num,
  output logic [15:0] wb_data,
  output logic [15:0] retire_count
);

  typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  load_dest_q, load_dest_d;
  logic        wb_en_q, wb_en_d;
  logic [2:0]  wb_num_q, wb_num_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [15:0] retire_count_q, retire_count_d;

  logic [3:0]  opcode;
  logic        unused_inputs;

  assign opcode        = execute_instr[15:12];
  assign store_src_num = execute_instr[2:0];
  // Writeback eligibility is fully captured by execute_done; the dependency flag is informational.
  assign unused_inputs = execute_is_dependent ^ (^execute_instr[11:3]);

  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    load_dest_d    = load_dest_q;
    wb_en_d        = 1'b0;
    wb_num_d       = wb_num_q;
    wb_data_d      = wb_data_q;
    retire_count_d = retire_count_q;
    case (state_q)
      IDLE: begin
        if (execute_done) begin
          wb_en_d        = 1'b1;
          wb_num_d       = execute_instr[2:0];
          wb_data_d      = execute_result;
          retire_count_d = retire_count_q + 16'd1;
        end else if (opcode == LOAD_OPC) begin
          state_d     = MEM_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = execute_result;
          load_dest_d = execute_instr[2:0];
        end else if (opcode == STORE_OPC) begin
          state_d     = MEM_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = execute_result;
          mem_wdata_d = store_data;
        end
      end
      MEM_WAIT: begin
        // Request fields stay frozen until memory responds; execute_* is ignored here.
        if (mem_ready) begin
          state_d        = IDLE;
          mem_req_d      = 1'b0;
          retire_count_d = retire_count_q + 16'd1;
          if (!mem_we_q) begin
            wb_en_d   = 1'b1;
            wb_num_d  = load_dest_q;
            wb_data_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 16'd0;
      mem_wdata_q    <= 16'd0;
      load_dest_q    <= 3'd0;
      wb_en_q        <= 1'b0;
      wb_num_q       <= 3'd0;
      wb_data_q      <= 16'd0;
      retire_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      load_dest_q    <= load_dest_d;
      wb_en_q        <= wb_en_d;
      wb_num_q       <= wb_num_d;
      wb_data_q      <= wb_data_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign stall        = (state_q == MEM_WAIT);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_en        = wb_en_q;
  assign wb_num       = wb_num_q;
  assign wb_data      = wb_data_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_pipeline_memory_writeback.sv
// Bench for pipeline_memory_writeback: directed scenarios plus a random instruction
// stream, compared each cycle against a transaction-level reference model.
module tb_pipeline_memory_writeback;

  localparam logic [3:0] LOAD  = 4'b1000;
  localparam logic [3:0] STORE = 4'b1001;

  logic        clk = 1'b0;
  logic        reset;
  logic        execute_done, execute_is_dependent;
  logic [15:0] execute_result, execute_instr, store_data;
  logic [2:0]  store_src_num;
  logic        stall, mem_req, mem_we, mem_ready, wb_en;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, wb_data, retire_count;
  logic [2:0]  wb_num;

  pipeline_memory_writeback dut (
    .clk(clk), .reset(reset),
    .execute_done(execute_done), .execute_is_dependent(execute_is_dependent),
    .execute_result(execute_result), .execute_instr(execute_instr),
    .store_src_num(store_src_num), .store_data(store_data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one outstanding memory transaction at most, plus the
  // writeback that is due in the current cycle and the architectural retire count.
  bit          busy;
  bit          op_load;
  logic [15:0] op_addr, op_wdata;
  logic [2:0]  op_dest;
  bit          due_wb;
  logic [2:0]  e_num;
  logic [15:0] e_data;
  logic [15:0] e_cnt;

  // held upstream instruction
  logic        cur_done;
  logic [15:0] cur_instr, cur_res, cur_sd;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("stall",        16'(stall),   16'(busy));
    chk("mem_req",      16'(mem_req), 16'(busy));
    if (busy) begin
      chk("mem_we",     16'(mem_we),  16'(!op_load));
      chk("mem_addr",   mem_addr,     op_addr);
      if (!op_load) chk("mem_wdata", mem_wdata, op_wdata);
    end
    chk("wb_en",        16'(wb_en),   16'(due_wb));
    chk("wb_num",       16'(wb_num),  16'(e_num));
    chk("wb_data",      wb_data,      e_data);
    chk("retire_count", retire_count, e_cnt);
  endtask

  task automatic cyc(input logic done, input logic [15:0] instr, input logic [15:0] res,
                     input logic [15:0] sd, input logic rdy, input logic [15:0] rd);
    execute_done         = done;
    execute_is_dependent = done;
    execute_instr        = instr;
    execute_result       = res;
    store_data           = sd;
    mem_ready            = rdy;
    mem_rdata            = rd;
    #1;
    chk("store_src_num", 16'(store_src_num), 16'(instr[2:0]));
    due_wb = 1'b0;
    if (!busy) begin
      if (done) begin
        due_wb = 1'b1; e_num = instr[2:0]; e_data = res; e_cnt = e_cnt + 16'd1;
      end else if (instr[15:12] == LOAD) begin
        busy = 1'b1; op_load = 1'b1; op_addr = res; op_dest = instr[2:0];
      end else if (instr[15:12] == STORE) begin
        busy = 1'b1; op_load = 1'b0; op_addr = res; op_wdata = sd;
      end
    end else if (rdy) begin
      busy  = 1'b0;
      e_cnt = e_cnt + 16'd1;
      if (op_load) begin
        due_wb = 1'b1; e_num = op_dest; e_data = rd;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busy = 1'b0; due_wb = 1'b0; e_num = 3'd0; e_data = 16'd0; e_cnt = 16'd0;
    check_outputs();
    chk("rst_mem_we",    16'(mem_we), 16'd0);
    chk("rst_mem_addr",  mem_addr,    16'd0);
    chk("rst_mem_wdata", mem_wdata,   16'd0);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] alu_opc();
    logic [3:0] op;
    op = 4'($urandom_range(0, 13));
    if (op >= 4'd8) op = op + 4'd2;
    return op;
  endfunction

  initial begin
    reset = 1'b1;
    execute_done = 1'b0; execute_is_dependent = 1'b0;
    execute_result = 16'd0; execute_instr = 16'd0; store_data = 16'd0;
    mem_ready = 1'b0; mem_rdata = 16'd0;
    busy = 1'b0; op_load = 1'b0; op_addr = 16'd0; op_wdata = 16'd0; op_dest = 3'd0;
    @(negedge clk);
    do_reset();

    // ALU retirement, 1-cycle latency
    cyc(1'b1, 16'h0003, 16'h1234, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0, 1'b0, 16'h0);

    // load with 3 wait cycles
    cyc(1'b0, 16'h8005, 16'h0040, 16'h0, 1'b0, 16'h0);
    repeat (3) cyc(1'b0, 16'h8005, 16'h0040, 16'h0, 1'b0, 16'h1111);
    cyc(1'b0, 16'h8005, 16'h0040, 16'h0, 1'b1, 16'hBEEF);
    chk("t2_wb_data", wb_data, 16'hBEEF);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0, 1'b0, 16'h0);

    // zero-wait store; ready during IDLE must be ignored
    cyc(1'b0, 16'h9002, 16'h0010, 16'hCAFE, 1'b1, 16'h0);
    cyc(1'b0, 16'h9002, 16'h0010, 16'h0BAD, 1'b1, 16'h0);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0, 1'b1, 16'h0);

    // reset aborts an outstanding load
    cyc(1'b0, 16'h8001, 16'h0020, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 16'h8001, 16'h0020, 16'h0, 1'b0, 16'h0);
    do_reset();
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0, 1'b1, 16'h7777);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0, 1'b0, 16'h0);
    chk("t4_count", retire_count, 16'h0000);

    // ALU, load (ready after 2 cycles), ALU back to back
    cyc(1'b1, 16'h0101, 16'hA001, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 16'h8006, 16'h0200, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 16'h8006, 16'h0200, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 16'h8006, 16'h0200, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 16'h8006, 16'h0200, 16'h0, 1'b1, 16'h5A5A);
    cyc(1'b1, 16'h0207, 16'hA002, 16'h0, 1'b0, 16'h0);
    chk("t6_wb_num", 16'(wb_num), 16'd7);
    cyc(1'b0, 16'h0000, 16'h0000, 16'h0, 1'b0, 16'h0);

    // random stream with upstream holding while a memory access is outstanding
    cur_done = 1'b0; cur_instr = 16'h0; cur_res = 16'h0; cur_sd = 16'h0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        if (!busy) begin
          cur_res = 16'($urandom);
          cur_sd  = 16'($urandom);
          case ($urandom_range(0, 3))
            0: begin cur_done = 1'b1; cur_instr = {alu_opc(), 12'($urandom)}; end
            1: begin cur_done = 1'b0; cur_instr = {alu_opc(), 12'($urandom)}; end
            2: begin cur_done = 1'b0; cur_instr = {LOAD, 12'($urandom)}; end
            default: begin cur_done = 1'b0; cur_instr = {STORE, 12'($urandom)}; end
          endcase
        end
        cyc(cur_done, cur_instr, cur_res, cur_sd, ($urandom_range(0, 2) == 0), 16'($urandom));
      end
    end

    // retire counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++)
      cyc(1'b1, {alu_opc(), 12'(i)}, 16'(i), 16'h0, 1'b0, 16'h0);
    chk("pre_wrap", retire_count, 16'hFFFF);
    cyc(1'b1, 16'h0004, 16'h4321, 16'h0, 1'b0, 16'h0);
    chk("wrap", retire_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_memory_writeback.md
Name: pipeline_memory_writeback

Overview:
- Final pipeline stage of the 16-bit CPU, downstream of the execute stage.
- Consumes the execute stage's registered outputs (done flag, dependency flag, result, instruction).
- ALU results are written back to the register file.
- Loads and stores run through a request/ready handshake with data memory; the block stalls the upstream stages while a memory access is outstanding.

Parameters:
LOAD_OPC, 4'b1000, instr[15:12] value identifying a load (address = execute_result, dest = instr[2:0])
STORE_OPC, 4'b1001, instr[15:12] value identifying a store (address = execute_result, data reg = instr[2:0])

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
execute_done  input  1  execute result is final (A/R-type per Constant.sv)
execute_is_dependent  input  1  instruction writes a register
execute_result  input  16  ALU result or memory address
execute_instr  input  16  instruction leaving execute
store_src_num  output  3  regfile read index for store data; combinational = execute_instr[2:0]
store_data  input  16  regfile read data for store_src_num
stall  output  1  hold fetch/execute outputs
mem_req  output  1  memory request valid
mem_we  output  1  1 = store, 0 = load
mem_addr  output  16  memory address
mem_wdata  output  16  store data
mem_ready  input  1  memory accepts/completes the request this cycle
mem_rdata  input  16  load data; valid when mem_ready=1
wb_en  output  1  register write strobe (one-cycle pulse)
wb_num  output  3  destination register
wb_data  output  16  write data
retire_count  output  16  retired-instruction counter

Behaviour:
Reset:
- Forces state IDLE.
- All outputs 0: stall, mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_num, wb_data, retire_count. Exception: store_src_num stays combinational.

Registered FSM, states IDLE and MEM_WAIT. stall = (state==MEM_WAIT), decoded from the state register only.

IDLE, sampled at each rising edge:
- execute_done=1: next cycle wb_en=1, wb_num=instr[2:0], wb_data=execute_result. Latency is 1 cycle. retire_count increments.
- opcode==LOAD_OPC: go to MEM_WAIT. mem_req=1, mem_we=0, mem_addr=execute_result.
- opcode==STORE_OPC: go to MEM_WAIT. mem_req=1, mem_we=1, mem_addr=execute_result, mem_wdata=store_data (captured at that edge).
- Any other instruction: bubble. No writeback, no count.
- The done check takes priority over the opcode check; the encodings do not overlap.

MEM_WAIT:
- mem_req, mem_we, mem_addr and mem_wdata are held stable until the edge where mem_ready=1.
- Edge with mem_ready=1:
  - mem_req drops next cycle; state returns to IDLE.
  - Load: wb_en pulses next cycle with wb_num=captured instr[2:0], wb_data=mem_rdata captured at that edge.
  - Store: no writeback.
  - Both cases: retire_count increments.
- execute_* inputs are ignored in MEM_WAIT. Upstream holds them stable while stall=1.
- The instruction presented when stall falls is sampled on the first IDLE edge.

General rules:
- wb_en is high for exactly one cycle per writeback. wb_num and wb_data keep their last values when wb_en=0.
- mem_ready while mem_req=0 is ignored.
- A zero-wait memory returns to IDLE after exactly one MEM_WAIT cycle, so a memory op costs 2 cycles total.
- retire_count wraps 16'hFFFF -> 16'h0000.
- reset asserted during MEM_WAIT aborts the access: mem_req=0 next cycle, no wb_en, no count. A later mem_ready is ignored.
- Back-to-back ALU instructions give wb_en every cycle with no stall.

Test Plan:
1. Reset, then ALU instr (execute_done=1, instr[2:0]=3, result=16'h1234) -> next cycle wb_en=1, wb_num=3, wb_data=16'h1234, retire_count=1, stall=0.
2. Load instr 16'h8005 (dest 5), result=16'h0040; mem_ready held low 3 cycles then high with mem_rdata=16'hBEEF -> mem_req=1 and addr=16'h0040 for 4 cycles, stall=1 throughout; cycle after ready: wb_en=1, wb_num=5, wb_data=16'hBEEF, stall=0.
3. Store instr 16'h9002, result=16'h0010, store_data=16'hCAFE, mem_ready=1 immediately -> store_src_num=2; one cycle of mem_req=1, mem_we=1, mem_wdata=16'hCAFE; no wb_en; retire_count increments.
4. Load in progress, reset pulsed for 1 cycle in MEM_WAIT, mem_ready raised afterwards -> mem_req=0, no wb_en, retire_count=0, stall=0.
5. Preload via 16'hFFFF ALU retirements (or forced), then one more ALU instr -> retire_count=16'h0000.
6. Stream ALU, load (ready after 2 cycles), ALU -> wb pulses in order; second ALU written exactly 1 cycle after stall falls; upstream-held inputs not double-retired.
